ysyx_22040931_scoreboard: RTL and testbench

YSYX_22040931_SCOREBOARD -- requirements
Module: ysyx_22040931_Scoreboard

---
 rtl/ysyx_22040931_scoreboard.sv | 137 +++++++++++++
 tb/tb_ysyx_22040931_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040931_scoreboard.sv
// rtl/ysyx_22040931_scoreboard.sv - register scoreboard with operand bypass and hazard stall
//
// Purpose: tracks in-flight destination writes per architectural register,
// selects bypassed operands from EX/MEM/WB, and raises stall for load-use,
// long-latency and pending-counter-full hazards.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   iss_*                        decode-slot instruction (sources, destination, handshake)
//   flush                        squash the decode slot
//   ex_*/mem_*/wb_*              producer write ports per pipeline stage
//   rf_data / fwd_data, fwd_sel  regfile operands in, resolved operands and source out
//   stall, nop                   hazard stall and downstream bubble request
//   outstanding, err             total pending writes, sticky counter fault flag
module ysyx_22040931_scoreboard #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NRP  = 2,
   parameter int CW   = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iss_valid,
   output logic                iss_ready,
   input  logic [NRP-1:0]      iss_rs_en,
   input  logic [NRP*AW-1:0]   iss_rs_addr,
   input  logic                iss_rd_en,
   input  logic [AW-1:0]       iss_rd_addr,
   input  logic                flush,
   input  logic                ex_w_ena,
   input  logic [AW-1:0]       ex_w_addr,
   input  logic [XLEN-1:0]     ex_w_data,
   input  logic                ex_is_load,
   input  logic                mem_w_ena,
   input  logic [AW-1:0]       mem_w_addr,
   input  logic [XLEN-1:0]     mem_w_data,
   input  logic                wb_w_ena,
   input  logic [AW-1:0]       wb_w_addr,
   input  logic [XLEN-1:0]     wb_w_data,
   input  logic [NRP*XLEN-1:0] rf_data,
   output logic [NRP*XLEN-1:0] fwd_data,
   output logic [NRP*2-1:0]    fwd_sel,
   output logic                stall,
   output logic                nop,
   output logic [AW+CW-1:0]    outstanding,
   output logic                err
);

   localparam int OW = AW + CW;
   localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] PEND_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [OW-1:0] OUT_ONE  = {{(OW-1){1'b0}}, 1'b1};

   logic [CW-1:0]  pend [NREG];
   logic [NRP-1:0] port_stall;
   logic           rd_full;

   genvar gp;
   generate
      for (gp = 0; gp < NRP; gp++) begin : g_port
         logic [AW-1:0] addr;
         logic          live;
         logic          hit_ex;
         logic          hit_mem;
         logic          hit_wb;

         assign addr    = iss_rs_addr[gp*AW +: AW];
         assign live    = iss_rs_en[gp] && (addr != '0);
         assign hit_ex  = live && ex_w_ena  && (ex_w_addr  == addr);
         assign hit_mem = live && mem_w_ena && (mem_w_addr == addr);
         assign hit_wb  = live && wb_w_ena  && (wb_w_addr  == addr);

         // Youngest producer wins: EX holds the newest value of the register.
         assign fwd_sel[gp*2 +: 2] = hit_ex  ? 2'b01 :
                                     hit_mem ? 2'b10 :
                                     hit_wb  ? 2'b11 : 2'b00;
         assign fwd_data[gp*XLEN +: XLEN] = hit_ex  ? ex_w_data  :
                                            hit_mem ? mem_w_data :
                                            hit_wb  ? wb_w_data  :
                                            rf_data[gp*XLEN +: XLEN];

         // A load in EX has no data yet; a pending write with no stage hit is
         // still in a long-latency unit and cannot be bypassed.
         assign port_stall[gp] = (hit_ex && ex_is_load) ||
                                 (live && !hit_ex && !hit_mem && !hit_wb && (pend[addr] != '0));
      end
   endgenerate

   assign rd_full   = iss_rd_en && (iss_rd_addr != '0) && (pend[iss_rd_addr] == PEND_MAX);
   assign stall     = iss_valid && ((|port_stall) || rd_full);
   assign iss_ready = iss_valid && !stall && !flush;
   assign nop       = (iss_valid && stall) || flush;

   logic inc;
   logic dec;
   logic same;
   logic inc_ok;
   logic dec_ok;
   logic inc_bad;
   logic dec_bad;

   assign inc  = iss_ready && iss_rd_en && (iss_rd_addr != '0);
   assign dec  = wb_w_ena && (wb_w_addr != '0);
   // Issue and retire of one register on the same edge cancel out.
   assign same = inc && dec && (iss_rd_addr == wb_w_addr);

   assign inc_ok  = inc && !same && (pend[iss_rd_addr] != PEND_MAX);
   assign inc_bad = inc && !same && (pend[iss_rd_addr] == PEND_MAX);
   assign dec_ok  = dec && !same && (pend[wb_w_addr] != '0);
   assign dec_bad = dec && !same && (pend[wb_w_addr] == '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) begin
            pend[r] <= '0;
         end
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         if (inc_ok) begin
            pend[iss_rd_addr] <= pend[iss_rd_addr] + PEND_ONE;
         end
         if (dec_ok) begin
            pend[wb_w_addr] <= pend[wb_w_addr] - PEND_ONE;
         end
         if (inc_ok && !dec_ok) begin
            outstanding <= outstanding + OUT_ONE;
         end else if (dec_ok && !inc_ok) begin
            outstanding <= outstanding - OUT_ONE;
         end
         if (inc_bad || dec_bad) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040931_scoreboard.sv
// tb/tb_ysyx_22040931_scoreboard.sv - self-checking bench for ysyx_22040931_scoreboard
module tb_ysyx_22040931_scoreboard;

   logic         clock = 1'b0;
   logic         reset;
   logic         iss_valid;
   logic         iss_ready;
   logic [1:0]   iss_rs_en;
   logic [9:0]   iss_rs_addr;
   logic         iss_rd_en;
   logic [4:0]   iss_rd_addr;
   logic         flush;
   logic         ex_w_ena;
   logic [4:0]   ex_w_addr;
   logic [63:0]  ex_w_data;
   logic         ex_is_load;
   logic         mem_w_ena;
   logic [4:0]   mem_w_addr;
   logic [63:0]  mem_w_data;
   logic         wb_w_ena;
   logic [4:0]   wb_w_addr;
   logic [63:0]  wb_w_data;
   logic [127:0] rf_data;
   logic [127:0] fwd_data;
   logic [3:0]   fwd_sel;
   logic         stall;
   logic         nop;
   logic [6:0]   outstanding;
   logic         err;

   always #5 clock = ~clock;

   ysyx_22040931_scoreboard dut (
      .clock(clock), .reset(reset),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs_en(iss_rs_en), .iss_rs_addr(iss_rs_addr),
      .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr),
      .flush(flush),
      .ex_w_ena(ex_w_ena), .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data), .ex_is_load(ex_is_load),
      .mem_w_ena(mem_w_ena), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
      .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
      .rf_data(rf_data), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
      .stall(stall), .nop(nop), .outstanding(outstanding), .err(err)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: plain per-register counts of writes not yet retired.
   int   pend_m [32];
   bit   err_m;
   logic [1:0]  e_sel  [2];
   logic [63:0] e_data [2];
   logic        e_stall, e_ready, e_nop;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int sum_pend();
      int s = 0;
      for (int r = 0; r < 32; r++) s += pend_m[r];
      return s;
   endfunction

   function automatic void model_comb();
      bit hz = 0;
      for (int p = 0; p < 2; p++) begin
         int a;
         a = int'(iss_rs_addr[p*5 +: 5]);
         e_sel[p]  = 2'b00;
         e_data[p] = rf_data[p*64 +: 64];
         if (iss_rs_en[p] && a != 0) begin
            if (ex_w_ena && int'(ex_w_addr) == a) begin
               e_sel[p] = 2'b01; e_data[p] = ex_w_data;
               if (ex_is_load) hz = 1;
            end else if (mem_w_ena && int'(mem_w_addr) == a) begin
               e_sel[p] = 2'b10; e_data[p] = mem_w_data;
            end else if (wb_w_ena && int'(wb_w_addr) == a) begin
               e_sel[p] = 2'b11; e_data[p] = wb_w_data;
            end else if (pend_m[a] > 0) begin
               hz = 1;
            end
         end
      end
      if (iss_rd_en && iss_rd_addr != 0 && pend_m[iss_rd_addr] == 3) hz = 1;
      e_stall = iss_valid && hz;
      e_ready = iss_valid && !e_stall && !flush;
      e_nop   = (iss_valid && e_stall) || flush;
   endfunction

   function automatic void model_edge();
      bit inc, dec;
      if (!reset) begin
         for (int r = 0; r < 32; r++) pend_m[r] = 0;
         err_m = 0;
         return;
      end
      inc = e_ready && iss_rd_en && iss_rd_addr != 0;
      dec = wb_w_ena && wb_w_addr != 0;
      if (inc && dec && iss_rd_addr == wb_w_addr) return;
      if (dec) begin
         if (pend_m[wb_w_addr] == 0) err_m = 1;
         else pend_m[wb_w_addr]--;
      end
      if (inc) begin
         if (pend_m[iss_rd_addr] == 3) err_m = 1;
         else pend_m[iss_rd_addr]++;
      end
   endfunction

   // Inputs are driven at the falling edge; combinational outputs are checked
   // just after, state outputs at the next falling edge.
   task automatic cycle();
      #1;
      model_comb();
      chk("stall", stall, e_stall);
      chk("iss_ready", iss_ready, e_ready);
      chk("nop", nop, e_nop);
      chk("fwd_sel", fwd_sel, {e_sel[1], e_sel[0]});
      chk("fwd_data", fwd_data, {e_data[1], e_data[0]});
      @(posedge clock);
      model_edge();
      @(negedge clock);
      chk("outstanding", outstanding, sum_pend());
      chk("err", err, err_m);
   endtask

   task automatic idle();
      reset = 1; iss_valid = 0; iss_rs_en = 0; iss_rs_addr = 0;
      iss_rd_en = 0; iss_rd_addr = 0; flush = 0;
      ex_w_ena = 0; ex_w_addr = 0; ex_w_data = 0; ex_is_load = 0;
      mem_w_ena = 0; mem_w_addr = 0; mem_w_data = 0;
      wb_w_ena = 0; wb_w_addr = 0; wb_w_data = 0;
      rf_data = {64'hAAAA_0001, 64'h5555_0000};
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      idle(); iss_valid = 1; iss_rd_en = 1; iss_rd_addr = rd;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) pend_m[r] = 0;
      err_m = 0;
      idle();
      reset = 0;
      cycle();
      cycle();
      idle();
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_nop", nop, 1'b0);
      chk("rst_ready", iss_ready, 1'b0);
      chk("rst_sel", fwd_sel, 4'b0);
      chk("rst_out", outstanding, 7'd0);
      cycle();

      // Bypass priority EX over MEM.
      idle(); iss_valid = 1; iss_rs_en = 2'b01; iss_rs_addr = {5'd0, 5'd5};
      ex_w_ena = 1; ex_w_addr = 5; ex_w_data = 64'h11;
      mem_w_ena = 1; mem_w_addr = 5; mem_w_data = 64'h22;
      #1;
      chk("byp_sel", fwd_sel[1:0], 2'b01);
      chk("byp_data", fwd_data[63:0], 64'h11);
      chk("byp_stall", stall, 1'b0);
      cycle();

      // Load-use on port 1, then the load reaches MEM.
      idle(); iss_valid = 1; iss_rs_en = 2'b10; iss_rs_addr = {5'd7, 5'd0};
      ex_w_ena = 1; ex_w_addr = 7; ex_w_data = 64'h77; ex_is_load = 1;
      #1;
      chk("lu_stall", stall, 1'b1);
      chk("lu_nop", nop, 1'b1);
      chk("lu_ready", iss_ready, 1'b0);
      cycle();
      ex_w_ena = 0; ex_is_load = 0; mem_w_ena = 1; mem_w_addr = 7; mem_w_data = 64'h77;
      #1;
      chk("lu_mem_sel", fwd_sel[3:2], 2'b10);
      chk("lu_mem_ready", iss_ready, 1'b1);
      cycle();

      // Long-latency producer on x9.
      issue_rd(9);
      cycle();
      idle(); iss_valid = 1; iss_rs_en = 2'b01; iss_rs_addr = {5'd0, 5'd9};
      #1;
      chk("ll_stall", stall, 1'b1);
      cycle();
      cycle();
      wb_w_ena = 1; wb_w_addr = 9; wb_w_data = 64'hABCD;
      #1;
      chk("ll_sel", fwd_sel[1:0], 2'b11);
      chk("ll_data", fwd_data[63:0], 64'hABCD);
      chk("ll_stall_off", stall, 1'b0);
      cycle();
      chk("ll_out", outstanding, 7'd0);

      // Saturation on x3, with a cancelling issue+retire on the way up.
      issue_rd(3); cycle();
      issue_rd(3); cycle();
      issue_rd(3); wb_w_ena = 1; wb_w_addr = 3; cycle();
      chk("sat_cancel", outstanding, 7'd2);
      issue_rd(3); cycle();
      chk("sat_out3", outstanding, 7'd3);
      issue_rd(3);
      #1;
      chk("sat_stall", stall, 1'b1);
      cycle();
      chk("sat_hold", outstanding, 7'd3);

      // x0 destination and flush.
      issue_rd(0); cycle();
      chk("x0_out", outstanding, 7'd3);
      issue_rd(4); flush = 1;
      #1;
      chk("flush_nop", nop, 1'b1);
      cycle();
      chk("flush_out", outstanding, 7'd3);

      // Reset with four writes pending; reset wins over issue and retire.
      issue_rd(10); cycle();
      chk("pre_rst_out", outstanding, 7'd4);
      issue_rd(11); wb_w_ena = 1; wb_w_addr = 3; reset = 0;
      cycle();
      chk("mid_rst_out", outstanding, 7'd0);
      chk("mid_rst_err", err, 1'b0);
      idle(); iss_valid = 1; iss_rs_en = 2'b11; iss_rs_addr = {5'd10, 5'd3};
      #1;
      chk("mid_rst_nostall", stall, 1'b0);
      cycle();

      // Retire of an idle register sets the sticky flag.
      idle(); wb_w_ena = 1; wb_w_addr = 12; cycle();
      chk("uflow_err", err, 1'b1);
      idle(); cycle();
      chk("uflow_sticky", err, 1'b1);
      idle(); reset = 0; cycle();

      // Randomized traffic on a small register window to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         idle();
         reset       = ($urandom_range(0, 49) != 0);
         iss_valid   = 1'($urandom);
         iss_rs_en   = 2'($urandom);
         iss_rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         iss_rd_en   = 1'($urandom);
         iss_rd_addr = 5'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 7) == 0);
         ex_w_ena    = ($urandom_range(0, 3) == 0);
         ex_w_addr   = 5'($urandom_range(0, 7));
         ex_w_data   = {$urandom, $urandom};
         ex_is_load  = 1'($urandom);
         mem_w_ena   = ($urandom_range(0, 3) == 0);
         mem_w_addr  = 5'($urandom_range(0, 7));
         mem_w_data  = {$urandom, $urandom};
         wb_w_ena    = ($urandom_range(0, 2) == 0);
         wb_w_addr   = 5'($urandom_range(0, 7));
         wb_w_data   = {$urandom, $urandom};
         rf_data     = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
